// File: rtl/vedic_mult64_seq_pkg.sv
// Shared types for the sequential 64x64 Vedic multiplier: FSM encoding,
// default widths, and the four-step partial-product schedule.
package vedic_mult64_seq_pkg;

    localparam int VM_W     = 64;
    localparam int VM_TAG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Left shift applied to a partial product before it joins the accumulator.
    typedef enum logic [1:0] {
        SH_NONE = 2'd0,  // << 0
        SH_HALF = 2'd1,  // << W/2
        SH_FULL = 2'd2   // << W
    } shift_e;

    typedef struct packed {
        logic   a_hi;  // use upper half of a
        logic   b_hi;  // use upper half of b
        shift_e sh;
    } pp_sel_t;

    // Step -> (half of a, half of b, shift): al*bl, al*bh, ah*bl, ah*bh.
    function automatic pp_sel_t pp_sched(input logic [1:0] cnt);
        pp_sel_t s;
        case (cnt)
            2'd0:    s = '{a_hi: 1'b0, b_hi: 1'b0, sh: SH_NONE};
            2'd1:    s = '{a_hi: 1'b0, b_hi: 1'b1, sh: SH_HALF};
            2'd2:    s = '{a_hi: 1'b1, b_hi: 1'b0, sh: SH_HALF};
            default: s = '{a_hi: 1'b1, b_hi: 1'b1, sh: SH_FULL};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/vedic_mult64_seq_vedic.sv
// Combinational Urdhva-Tiryagbhyam multiplier. vedic_cell splits each operand
// into halves, forms the four cross products with half-size cells and sums
// them with the middle terms shifted by N/2; recursion ends at a 2-bit gate
// level cell. vedic_mult32 is the W/2 x W/2 core used by the sequencer.
module vedic_cell #(
    parameter int N = 32
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    if (N == 2) begin : g_leaf
        // 2-bit vertical-and-crosswise cell built from AND/half-adder gates
        logic t1, t2, c1, t3;
        assign t1   = a[1] & b[0];
        assign t2   = a[0] & b[1];
        assign c1   = t1 & t2;
        assign t3   = a[1] & b[1];
        assign p[0] = a[0] & b[0];
        assign p[1] = t1 ^ t2;
        assign p[2] = t3 ^ c1;
        assign p[3] = t3 & c1;
    end else if ((N > 2) && (N % 2 == 0)) begin : g_split
        localparam int H = N / 2;
        logic [N-1:0]   ll, lh, hl, hh;
        logic [2*N-1:0] mid;
        vedic_cell #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
        vedic_cell #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
        vedic_cell #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
        vedic_cell #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));
        // crosswise terms share weight 2^H; vertical terms sit side by side
        assign mid = {{N{1'b0}}, lh} + {{N{1'b0}}, hl};
        assign p   = {hh, ll} + (mid << H);
    end else begin : g_odd
        // widths that do not halve cleanly fall back to a plain product
        assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    end
endmodule

module vedic_mult32 #(
    parameter int N = 32
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    vedic_cell #(.N(N)) u_core (.a(a), .b(b), .p(p));
endmodule

// File: rtl/vedic_mult64_seq.sv
// Sequential W x W unsigned multiplier: one W/2 x W/2 Vedic core reused over
// four cycles, partial products accumulated into a 2W-bit register.
// Valid/ready on both sides; the tag rides along with each operand pair.
module vedic_mult64_seq
    import vedic_mult64_seq_pkg::*;
#(
    parameter int W     = VM_W,
    parameter int TAG_W = VM_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z,
    output logic [TAG_W-1:0] out_tag
);
    localparam int H = W / 2;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [2*W-1:0]   acc_q, acc_d;

    pp_sel_t          sel;
    logic [H-1:0]     op_a, op_b;
    logic [W-1:0]     pp;
    logic [2*W-1:0]   pp_sh;

    // Pick operand halves and shift for the current step
    always_comb begin
        sel   = pp_sched(cnt_q);
        op_a  = sel.a_hi ? a_q[W-1:H] : a_q[H-1:0];
        op_b  = sel.b_hi ? b_q[W-1:H] : b_q[H-1:0];
        case (sel.sh)
            SH_NONE: pp_sh = {{W{1'b0}}, pp};
            SH_HALF: pp_sh = {{H{1'b0}}, pp, {H{1'b0}}};
            default: pp_sh = {pp, {W{1'b0}}};
        endcase
    end

    vedic_mult32 #(.N(H)) u_core (.a(op_a), .b(op_b), .p(pp));

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign z         = acc_q;
    assign out_tag   = tag_q;

    // Next-state: accept, four accumulate steps, then hold until drained
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    tag_d   = in_tag;
                    acc_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                // sum is bounded by (2^W-1)^2, so 2W bits never overflow
                acc_d = acc_q + pp_sh;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b;
                        tag_d   = in_tag;
                        acc_d   = '0;
                        cnt_d   = 2'd0;
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
        end
    end

endmodule
